// File: rtl/frame_buffer_arbiter.sv
// Single-port frame buffer arbiter: scanout reads own every active-video cycle,
// client writes slip into blanking through a small IDLE/SCAN/WRITE/ACK FSM.
module frame_buffer_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset_L,
    input  logic              blank,
    input  logic [8:0]        row,
    input  logic [9:0]        col,
    input  logic              wr_req,
    input  logic [18:0]       wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              wr_err,
    output logic [18:0]       mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pixel,
    output logic              pixel_valid
);
    localparam int STAGES = 2;

    typedef enum logic [1:0] {IDLE, SCAN, WRITE, ACK} state_t;

    state_t              state, state_nxt;
    logic                in_range;
    logic                wr_slot;
    logic                err_q;
    logic [STAGES:1]     vld_pipe;
    logic [DATA_W-1:0]   pixel_q;

    assign in_range = (wr_addr[18:10] <= 9'd479) && (wr_addr[9:0] <= 10'd639);
    // The write slot only exists while blanking; active video steals the port.
    assign wr_slot  = (state == WRITE) && blank;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = !blank ? SCAN : (wr_req ? WRITE : IDLE);
            SCAN:    state_nxt = blank ? IDLE : SCAN;
            WRITE:   state_nxt = blank ? ACK  : SCAN;
            ACK:     state_nxt = blank ? IDLE : SCAN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L)     err_q <= 1'b0;
        else if (wr_slot) err_q <= !in_range;
    end

    assign wr_ack    = (state == ACK);
    assign wr_err    = (state == ACK) && err_q;
    assign mem_we    = wr_slot && in_range;
    assign mem_addr  = wr_slot ? wr_addr : {row, col};
    assign mem_wdata = wr_data;

    // Stage 1: a read went out last cycle, so mem_rdata is live now.
    // Stage 2: the captured pixel is valid.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            vld_pipe <= '0;
            pixel_q  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1], !blank};
            pixel_q  <= vld_pipe[1] ? mem_rdata : '0;
        end
    end

    assign pixel       = pixel_q;
    assign pixel_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter: per-cycle vector table plus
// hand-written abort, back-to-back, dropped-request and reset sequences.
module tb_frame_buffer_arbiter;
    logic        clock;
    logic        reset_L;
    logic        blank;
    logic [8:0]  row;
    logic [9:0]  col;
    logic        wr_req;
    logic [18:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic        wr_err;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  pixel;
    logic        pixel_valid;

    int n_cmp = 0;
    int n_err = 0;

    frame_buffer_arbiter #(.DATA_W(8)) dut (
        .clock(clock), .reset_L(reset_L), .blank(blank), .row(row), .col(col),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .wr_err(wr_err), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pixel(pixel), .pixel_valid(pixel_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish by time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       blank;
        logic [8:0] row;
        logic [9:0] col;
        logic       req;
        logic [8:0] ar;
        logic [9:0] ac;
        logic [7:0] data;
        logic [7:0] rdata;
        logic       e_we;
        logic [8:0] e_row;
        logic [9:0] e_col;
        logic       e_ack;
        logic       e_err;
        logic [7:0] e_pix;
        logic       e_pv;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic b, input int r, input int c, input logic q,
                       input int ar, input int ac, input logic [7:0] d, input logic [7:0] rd,
                       input logic we, input int er, input int ec, input logic ack,
                       input logic err, input logic [7:0] pix, input logic pv);
        vec_t v;
        v.blank = b;  v.row = 9'(r);  v.col = 10'(c);  v.req = q;
        v.ar = 9'(ar); v.ac = 10'(ac); v.data = d;  v.rdata = rd;
        v.e_we = we;  v.e_row = 9'(er); v.e_col = 10'(ec); v.e_ack = ack;
        v.e_err = err; v.e_pix = pix; v.e_pv = pv;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic b, input int r, input int c, input logic q,
                         input int ar, input int ac, input logic [7:0] d, input logic [7:0] rd);
        blank = b; row = 9'(r); col = 10'(c); wr_req = q;
        wr_addr = {9'(ar), 10'(ac)}; wr_data = d; mem_rdata = rd;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int we_n, ack_n, last_we, min_gap, overlap, bad;

        // blank, row, col, req, addr_row, addr_col, data, rdata | we, addr_row, addr_col, ack, err, pixel, pv
        add(0,5,10,   0,0,0,8'h00,8'h00,     0,5,10,   0,0,8'h00,0);
        add(1,1,2,    0,0,0,8'h00,8'hA5,     0,1,2,    0,0,8'h00,0);
        add(0,7,3,    0,0,0,8'h00,8'h11,     0,7,3,    0,0,8'hA5,1);
        add(1,1,2,    0,0,0,8'h00,8'h5A,     0,1,2,    0,0,8'h00,0);
        add(1,1,2,    1,100,200,8'h3C,8'hFF, 0,1,2,    0,0,8'h5A,1);
        add(1,1,2,    1,100,200,8'h3C,8'hFF, 1,100,200,0,0,8'h00,0);
        add(1,1,2,    1,100,200,8'h3C,8'hFF, 0,1,2,    1,0,8'h00,0);
        add(1,1,2,    0,0,0,8'h00,8'h00,     0,1,2,    0,0,8'h00,0);
        add(1,1,2,    1,480,0,8'h77,8'h00,   0,1,2,    0,0,8'h00,0);
        add(1,1,2,    1,480,0,8'h77,8'h00,   0,480,0,  0,0,8'h00,0);
        add(1,1,2,    1,480,0,8'h77,8'h00,   0,1,2,    1,1,8'h00,0);
        add(1,1,2,    1,0,640,8'h66,8'h00,   0,1,2,    0,0,8'h00,0);
        add(1,1,2,    1,0,640,8'h66,8'h00,   0,0,640,  0,0,8'h00,0);
        add(1,1,2,    1,0,640,8'h66,8'h00,   0,1,2,    1,1,8'h00,0);
        add(1,1,2,    1,479,639,8'h81,8'h00, 0,1,2,    0,0,8'h00,0);
        add(1,1,2,    1,479,639,8'h81,8'h00, 1,479,639,0,0,8'h00,0);
        add(1,1,2,    1,479,639,8'h81,8'h00, 0,1,2,    1,0,8'h00,0);
        add(0,2,4,    0,0,0,8'h00,8'h00,     0,2,4,    0,0,8'h00,0);
        add(0,2,5,    0,0,0,8'h00,8'hC3,     0,2,5,    0,0,8'h00,0);
        add(0,2,6,    0,0,0,8'h00,8'h3C,     0,2,6,    0,0,8'hC3,1);
        add(1,1,2,    0,0,0,8'h00,8'h99,     0,1,2,    0,0,8'h3C,1);
        add(1,1,2,    0,0,0,8'h00,8'h44,     0,1,2,    0,0,8'h99,1);
        add(1,1,2,    0,0,0,8'h00,8'h00,     0,1,2,    0,0,8'h00,0);

        reset_L = 1'b0;
        drive(1,3,7,0,0,0,8'h00,8'h00);
        #2;
        chk("reset wr_ack", 32'(wr_ack), 0);
        chk("reset wr_err", 32'(wr_err), 0);
        chk("reset mem_we", 32'(mem_we), 0);
        chk("reset pixel", 32'(pixel), 0);
        chk("reset pixel_valid", 32'(pixel_valid), 0);
        chk("reset mem_addr", 32'(mem_addr), 32'({9'd3, 10'd7}));
        next_cycle();
        next_cycle();
        reset_L = 1'b1;
        drive(1,1,2,0,0,0,8'h00,8'h00);
        next_cycle();
        next_cycle();

        foreach (vt[i]) begin
            drive(vt[i].blank, int'(vt[i].row), int'(vt[i].col), vt[i].req,
                  int'(vt[i].ar), int'(vt[i].ac), vt[i].data, vt[i].rdata);
            @(negedge clock);
            chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vt[i].e_we));
            chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'({vt[i].e_row, vt[i].e_col}));
            chk($sformatf("v%0d mem_wdata", i), 32'(mem_wdata), 32'(vt[i].data));
            chk($sformatf("v%0d wr_ack", i), 32'(wr_ack), 32'(vt[i].e_ack));
            chk($sformatf("v%0d wr_err", i), 32'(wr_err), 32'(vt[i].e_err));
            chk($sformatf("v%0d pixel", i), 32'(pixel), 32'(vt[i].e_pix));
            chk($sformatf("v%0d pixel_valid", i), 32'(pixel_valid), 32'(vt[i].e_pv));
            next_cycle();
        end

        // Abort: blank drops while in WRITE, write retried in the next blanking.
        drive(1,1,2,1,10,20,8'h5E,8'h00);
        @(negedge clock); chk("abort idle mem_we", 32'(mem_we), 0);
        next_cycle();
        drive(0,3,4,1,10,20,8'h5E,8'h00);
        @(negedge clock);
        chk("abort write mem_we", 32'(mem_we), 0);
        chk("abort write mem_addr", 32'(mem_addr), 32'({9'd3, 10'd4}));
        chk("abort write wr_ack", 32'(wr_ack), 0);
        next_cycle();
        @(negedge clock); chk("abort scan wr_ack", 32'(wr_ack), 0);
        next_cycle();
        drive(1,1,2,1,10,20,8'h5E,8'h00);
        @(negedge clock); chk("abort blank wr_ack", 32'(wr_ack), 0);
        next_cycle();
        @(negedge clock); chk("abort idle2 mem_we", 32'(mem_we), 0);
        next_cycle();
        @(negedge clock);
        chk("abort retry mem_we", 32'(mem_we), 1);
        chk("abort retry mem_addr", 32'(mem_addr), 32'({9'd10, 10'd20}));
        chk("abort retry mem_wdata", 32'(mem_wdata), 32'h5E);
        next_cycle();
        @(negedge clock);
        chk("abort retry wr_ack", 32'(wr_ack), 1);
        chk("abort retry wr_err", 32'(wr_err), 0);
        next_cycle();
        drive(1,1,2,0,0,0,8'h00,8'h00);
        next_cycle();

        // Request dropped while in WRITE still completes.
        drive(1,1,2,1,30,40,8'h0D,8'h00);
        next_cycle();
        wr_req = 1'b0;
        @(negedge clock);
        chk("dropreq mem_we", 32'(mem_we), 1);
        chk("dropreq mem_addr", 32'(mem_addr), 32'({9'd30, 10'd40}));
        next_cycle();
        @(negedge clock);
        chk("dropreq wr_ack", 32'(wr_ack), 1);
        chk("dropreq wr_err", 32'(wr_err), 0);
        next_cycle();
        @(negedge clock);
        chk("dropreq idle wr_ack", 32'(wr_ack), 0);
        next_cycle();

        // Back-to-back: request held high through three writes.
        drive(1,1,2,1,200,300,8'hB7,8'h00);
        we_n = 0; ack_n = 0; last_we = -10; min_gap = 100; overlap = 0; bad = 0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clock);
            if (mem_we) begin
                if (k - last_we < min_gap) min_gap = k - last_we;
                last_we = k;
                we_n++;
            end
            if (wr_ack) ack_n++;
            if (wr_ack && mem_we) overlap++;
            if (wr_err) bad++;
            next_cycle();
        end
        drive(1,1,2,0,0,0,8'h00,8'h00);
        chk("b2b write count", 32'(we_n), 3);
        chk("b2b ack count", 32'(ack_n), 3);
        chk("b2b min write spacing>=2", 32'(min_gap >= 2), 1);
        chk("b2b write during ack", 32'(overlap), 0);
        chk("b2b wr_err", 32'(bad), 0);
        next_cycle();

        // Reset asserted in the middle of a WRITE cycle.
        drive(1,6,9,1,50,60,8'h5F,8'h00);
        next_cycle();
        chk("rstmid write mem_we", 32'(mem_we), 1);
        #2;
        reset_L = 1'b0;
        #1;
        chk("rstmid mem_we", 32'(mem_we), 0);
        chk("rstmid wr_ack", 32'(wr_ack), 0);
        chk("rstmid wr_err", 32'(wr_err), 0);
        chk("rstmid pixel", 32'(pixel), 0);
        chk("rstmid pixel_valid", 32'(pixel_valid), 0);
        chk("rstmid mem_addr", 32'(mem_addr), 32'({9'd6, 10'd9}));
        next_cycle();
        reset_L = 1'b1;
        wr_req = 1'b0;
        ack_n = 0; we_n = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (wr_ack) ack_n++;
            if (mem_we) we_n++;
            next_cycle();
        end
        chk("rstmid ack after release", 32'(ack_n), 0);
        chk("rstmid write after release", 32'(we_n), 0);
        wr_req = 1'b1;
        next_cycle();
        @(negedge clock);
        chk("rstmid new write mem_we", 32'(mem_we), 1);
        next_cycle();
        @(negedge clock);
        chk("rstmid new write wr_ack", 32'(wr_ack), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
